// File: rtl/can_timing_pkg.sv
// CAN bit-timing shared types: FSM state encoding and default field widths,
// common to the timing engine, hard_sync and the bit stream processor.
package can_timing_pkg;

  localparam int DEF_BRP_W   = 6;
  localparam int DEF_TSEG1_W = 4;
  localparam int DEF_TSEG2_W = 3;
  localparam int DEF_SJW_W   = 2;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_SYNC_SEG = 2'd1,
    ST_TSEG1    = 2'd2,
    ST_TSEG2    = 2'd3
  } bt_state_t;

endpackage

// File: rtl/bit_timing_fsm_tq_prescaler.sv
// Time-quantum prescaler: counts 0..brp and flags the last cycle of each TQ.
// A synchronous clear realigns the TQ grid on bit start or hard sync.
module tq_prescaler
  import can_timing_pkg::*;
#(
  parameter int BRP_W = DEF_BRP_W
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic [BRP_W-1:0] brp,
  output logic             tq_tick
);

  logic [BRP_W-1:0] r_cnt;

  assign tq_tick = (r_cnt == brp);

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      r_cnt <= '0;
    end else if (tq_tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/bit_timing_fsm.sv
// CAN bit timing engine: SYNC_SEG/TSEG1/TSEG2 sequencing in time quanta,
// with hard sync, single-resync-per-bit phase correction and sampling.
module bit_timing_fsm
  import can_timing_pkg::*;
#(
  parameter int BRP_W   = DEF_BRP_W,
  parameter int TSEG1_W = DEF_TSEG1_W,
  parameter int TSEG2_W = DEF_TSEG2_W,
  parameter int SJW_W   = DEF_SJW_W
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               enable,
  input  logic [BRP_W-1:0]   brp,
  input  logic [TSEG1_W-1:0] tseg1,
  input  logic [TSEG2_W-1:0] tseg2,
  input  logic [SJW_W-1:0]   sjw,
  input  logic               signal_in,
  input  logic               falling_edge,
  input  logic               hard_sync_request,
  output logic               sample_point,
  output logic               sampled_bit,
  output logic               tx_point
);

  // Wide enough for the longest stretched TSEG1 (16 + 4 TQ).
  localparam int CNT_W = TSEG1_W + 1;

  bt_state_t        r_state;
  logic [BRP_W-1:0] r_brp;
  logic [CNT_W-1:0] r_tseg1_len;
  logic [CNT_W-1:0] r_tseg2_len;
  logic [CNT_W-1:0] r_sjw_len;
  logic [CNT_W-1:0] r_t1_tgt;
  logic [CNT_W-1:0] r_t2_tgt;
  logic [CNT_W-1:0] r_tq_cnt;
  logic             r_resync_used;

  logic             w_tq_tick;
  logic             w_clear;
  logic             w_resync;
  logic             w_seg_done;
  logic             w_enter_sync;
  logic [CNT_W-1:0] w_n1;
  logic [CNT_W-1:0] w_err;
  logic [CNT_W-1:0] w_t1_new;
  logic [CNT_W-1:0] w_t2_floor;
  logic [CNT_W-1:0] w_t2_new;
  logic [CNT_W-1:0] w_tgt;

  assign w_clear = !enable || hard_sync_request
                || (r_state == ST_IDLE);

  tq_prescaler #(
    .BRP_W (BRP_W)
  ) u_presc (
    .clock   (clock),
    .reset   (reset),
    .clear   (w_clear),
    .brp     (r_brp),
    .tq_tick (w_tq_tick)
  );

  assign w_resync = falling_edge && !hard_sync_request
                 && ((r_state == ST_TSEG1) || (r_state == ST_TSEG2))
                 && sampled_bit && !r_resync_used;

  // n completed TQs in the segment; phase error in TSEG1 is n+1.
  assign w_n1       = r_tq_cnt + 1'b1;
  assign w_err      = (w_n1 < r_sjw_len) ? w_n1 : r_sjw_len;
  assign w_t1_new   = r_tseg1_len + w_err;
  assign w_t2_floor = (r_tseg2_len > r_sjw_len)
                    ? (r_tseg2_len - r_sjw_len) : '0;
  assign w_t2_new   = (w_n1 > w_t2_floor) ? w_n1 : w_t2_floor;

  always_comb begin
    w_tgt = CNT_W'(1);
    unique case (r_state)
      ST_TSEG1: w_tgt = w_resync ? w_t1_new : r_t1_tgt;
      ST_TSEG2: w_tgt = w_resync ? w_t2_new : r_t2_tgt;
      default:  w_tgt = CNT_W'(1);
    endcase
  end

  assign w_seg_done   = w_tq_tick && (w_n1 >= w_tgt);
  assign w_enter_sync = hard_sync_request || (r_state == ST_IDLE)
                     || ((r_state == ST_TSEG2) && w_seg_done);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state       <= ST_IDLE;
      r_brp         <= '0;
      r_tseg1_len   <= '0;
      r_tseg2_len   <= '0;
      r_sjw_len     <= '0;
      r_t1_tgt      <= '0;
      r_t2_tgt      <= '0;
      r_tq_cnt      <= '0;
      r_resync_used <= 1'b0;
      sample_point  <= 1'b0;
      tx_point      <= 1'b0;
      sampled_bit   <= 1'b1;
    end else begin
      sample_point <= 1'b0;
      tx_point     <= 1'b0;
      if (!enable) begin
        r_state       <= ST_IDLE;
        r_tq_cnt      <= '0;
        r_resync_used <= 1'b0;
      end else if (w_enter_sync) begin
        r_state       <= ST_SYNC_SEG;
        r_tq_cnt      <= '0;
        r_resync_used <= 1'b0;
        r_brp         <= brp;
        r_tseg1_len   <= CNT_W'(tseg1) + CNT_W'(1);
        r_tseg2_len   <= CNT_W'(tseg2) + CNT_W'(1);
        r_sjw_len     <= CNT_W'(sjw) + CNT_W'(1);
        r_t1_tgt      <= CNT_W'(tseg1) + CNT_W'(1);
        r_t2_tgt      <= CNT_W'(tseg2) + CNT_W'(1);
        tx_point      <= 1'b1;
      end else begin
        if (w_resync) begin
          r_resync_used <= 1'b1;
          if (r_state == ST_TSEG1) begin
            r_t1_tgt <= w_t1_new;
          end else begin
            r_t2_tgt <= w_t2_new;
          end
        end
        if (w_tq_tick) begin
          r_tq_cnt <= w_seg_done ? '0 : w_n1;
          if (w_seg_done) begin
            unique case (r_state)
              ST_SYNC_SEG: r_state <= ST_TSEG1;
              ST_TSEG1: begin
                r_state      <= ST_TSEG2;
                sample_point <= 1'b1;
                sampled_bit  <= signal_in;
              end
              default: ;
            endcase
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_bit_timing_fsm.sv
// Bench for bit_timing_fsm: directed bit-length vectors, hand sequences,
// and randomized traffic against a bit-position reference model.
module tb_bit_timing_fsm;

  logic       clock = 1'b0;
  logic       reset;
  logic       enable;
  logic [5:0] brp;
  logic [3:0] tseg1;
  logic [2:0] tseg2;
  logic [1:0] sjw;
  logic       signal_in;
  logic       falling_edge;
  logic       hard_sync_request;
  logic       sample_point;
  logic       sampled_bit;
  logic       tx_point;

  int checks = 0;
  int errors = 0;

  bit_timing_fsm dut (
    .clock             (clock),
    .reset             (reset),
    .enable            (enable),
    .brp               (brp),
    .tseg1             (tseg1),
    .tseg2             (tseg2),
    .sjw               (sjw),
    .signal_in         (signal_in),
    .falling_edge      (falling_edge),
    .hard_sync_request (hard_sync_request),
    .sample_point      (sample_point),
    .sampled_bit       (sampled_bit),
    .tx_point          (tx_point)
  );

  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Directed vectors: event kind 1 = falling_edge, 2 = hard sync,
  // injected at a cycle offset from the tx_point of the measured bit.
  typedef struct {
    string name;
    int    sig;
    int    k1;
    int    c1;
    int    k2;
    int    c2;
    int    exp_sp;
    int    exp_len;
  } vec_t;

  function automatic vec_t mk(string n, int sig, int k1, int c1,
                              int k2, int c2, int sp, int len);
    vec_t v;
    v.name = n; v.sig = sig;
    v.k1 = k1; v.c1 = c1; v.k2 = k2; v.c2 = c2;
    v.exp_sp = sp; v.exp_len = len;
    return v;
  endfunction

  task automatic measure(input int k1, input int c1, input int k2,
                         input int c2, output int sp, output int len);
    sp  = -1;
    len = -1;
    for (int o = 0; o < 60; o++) begin
      falling_edge      = (k1 == 1 && c1 == o) || (k2 == 1 && c2 == o);
      hard_sync_request = (k1 == 2 && c1 == o) || (k2 == 2 && c2 == o);
      step();
      falling_edge      = 1'b0;
      hard_sync_request = 1'b0;
      if (sample_point && sp < 0) sp = o + 1;
      if (tx_point) begin
        len = o + 1;
        break;
      end
    end
  endtask

  task automatic start_run(input logic sig);
    int sp;
    int len;
    reset = 1'b1; enable = 1'b0;
    brp = 6'd1; tseg1 = 4'd5; tseg2 = 3'd2; sjw = 2'd1;
    falling_edge = 1'b0; hard_sync_request = 1'b0;
    signal_in = sig;
    step();
    step();
    reset = 1'b0; enable = 1'b1;
    step();
    chk("tx_on_enable", 32'(tx_point), 32'd1);
    measure(0, 0, 0, 0, sp, len);
    chk("warm_sp", sp, 14);
    chk("warm_len", len, 20);
  endtask

  // Reference model: tracks the cycle offset k inside the current bit and
  // derives the segment and phase from k / TQ-length arithmetic.
  bit m_on, m_used, m_sbit, m_tx, m_sp;
  int m_k, m_p, m_l1, m_l2, m_sj, m_t1, m_t2;

  task automatic m_new_bit();
    m_on = 1'b1; m_k = 0; m_used = 1'b0; m_tx = 1'b1;
    m_p  = int'(brp) + 1;
    m_l1 = int'(tseg1) + 1;
    m_l2 = int'(tseg2) + 1;
    m_sj = int'(sjw) + 1;
    m_t1 = m_l1;
    m_t2 = m_l2;
  endtask

  task automatic m_step();
    int tq;
    int n;
    bit tick;
    m_tx = 1'b0;
    m_sp = 1'b0;
    if (reset) begin
      m_on = 1'b0; m_used = 1'b0; m_sbit = 1'b1;
    end else if (!enable) begin
      m_on = 1'b0;
    end else if (!m_on || hard_sync_request) begin
      m_new_bit();
    end else begin
      tq   = m_k / m_p;
      tick = (m_k % m_p) == m_p - 1;
      if (falling_edge && m_sbit && !m_used && tq >= 1) begin
        m_used = 1'b1;
        if (tq < 1 + m_t1) begin
          n    = tq - 1;
          m_t1 = m_l1 + ((n + 1 < m_sj) ? n + 1 : m_sj);
        end else begin
          n    = tq - 1 - m_t1;
          m_t2 = (n + 1 > m_l2 - m_sj) ? n + 1 : m_l2 - m_sj;
        end
      end
      if (tick && tq + 1 == 1 + m_t1) begin
        m_sp   = 1'b1;
        m_sbit = signal_in;
      end
      if (tick && tq + 1 == 1 + m_t1 + m_t2) m_new_bit();
      else m_k++;
    end
  endtask

  vec_t vecs[11];

  initial begin
    int sp;
    int len;
    vecs[0]  = mk("nominal",     1, 0, 0,  0, 0,  14, 20);
    vecs[1]  = mk("edge_sync",   1, 1, 1,  0, 0,  14, 20);
    vecs[2]  = mk("t1_n0",       1, 1, 2,  0, 0,  16, 22);
    vecs[3]  = mk("t1_n1",       1, 1, 4,  0, 0,  18, 24);
    vecs[4]  = mk("t1_n4_cap",   1, 1, 10, 0, 0,  18, 24);
    vecs[5]  = mk("t2_n0",       1, 1, 14, 0, 0,  14, 16);
    vecs[6]  = mk("t2_n1",       1, 1, 16, 0, 0,  14, 18);
    vecs[7]  = mk("second_edge", 1, 1, 2,  1, 16, 16, 22);
    vecs[8]  = mk("sbit0_edge",  0, 1, 2,  0, 0,  14, 20);
    vecs[9]  = mk("hs_tseg2",    1, 2, 16, 0, 0,  14, 17);
    vecs[10] = mk("hs_over_edge",1, 2, 4,  1, 4,  -1, 5);

    reset = 1'b1; enable = 1'b1;
    brp = 6'd1; tseg1 = 4'd5; tseg2 = 3'd2; sjw = 2'd1;
    signal_in = 1'b0; falling_edge = 1'b0; hard_sync_request = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst_tx", 32'(tx_point), 32'd0);
      chk("rst_sp", 32'(sample_point), 32'd0);
      chk("rst_sbit", 32'(sampled_bit), 32'd1);
    end
    hard_sync_request = 1'b0;

    foreach (vecs[i]) begin
      start_run(vecs[i].sig[0]);
      measure(vecs[i].k1, vecs[i].c1, vecs[i].k2, vecs[i].c2, sp, len);
      chk({vecs[i].name, "_sp"}, sp, vecs[i].exp_sp);
      chk({vecs[i].name, "_len"}, len, vecs[i].exp_len);
      chk({vecs[i].name, "_sbit"}, 32'(sampled_bit), vecs[i].sig);
    end

    // Hard sync realigns the grid; next bit is nominal.
    start_run(1'b1);
    measure(2, 16, 0, 0, sp, len);
    chk("hs_len", len, 17);
    measure(0, 0, 0, 0, sp, len);
    chk("hs_next_sp", sp, 14);
    chk("hs_next_len", len, 20);

    // Reset mid-TSEG1 beats hard sync and edges; restart on enable.
    start_run(1'b0);
    for (int i = 0; i < 5; i++) step();
    reset = 1'b1; hard_sync_request = 1'b1; falling_edge = 1'b1;
    step();
    chk("midrst_tx", 32'(tx_point), 32'd0);
    chk("midrst_sp", 32'(sample_point), 32'd0);
    chk("midrst_sbit", 32'(sampled_bit), 32'd1);
    reset = 1'b0; hard_sync_request = 1'b0; falling_edge = 1'b0;
    step();
    chk("midrst_restart_tx", 32'(tx_point), 32'd1);
    measure(0, 0, 0, 0, sp, len);
    chk("midrst_sp_off", sp, 14);
    chk("midrst_len", len, 20);

    // Enable toggle mid-bit.
    for (int i = 0; i < 3; i++) step();
    enable = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("dis_tx", 32'(tx_point), 32'd0);
      chk("dis_sp", 32'(sample_point), 32'd0);
    end
    enable = 1'b1;
    step();
    chk("en_tx", 32'(tx_point), 32'd1);
    measure(0, 0, 0, 0, sp, len);
    chk("en_sp_off", sp, 14);
    chk("en_len", len, 20);

    // Randomized traffic against the reference model.
    reset = 1'b1; enable = 1'b0;
    falling_edge = 1'b0; hard_sync_request = 1'b0;
    @(posedge clock);
    m_step();
    #1;
    reset = 1'b0; enable = 1'b1;
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(99) < 5) brp = 6'($urandom_range(3));
      if ($urandom_range(99) < 5) tseg1 = 4'($urandom_range(15));
      if ($urandom_range(99) < 5) tseg2 = 3'($urandom_range(7));
      if ($urandom_range(99) < 5) sjw = 2'($urandom_range(3));
      signal_in         = 1'($urandom_range(1));
      falling_edge      = ($urandom_range(99) < 12);
      hard_sync_request = ($urandom_range(299) == 0);
      reset             = ($urandom_range(499) == 0);
      if (enable && $urandom_range(99) == 0) enable = 1'b0;
      else if (!enable && $urandom_range(99) < 30) enable = 1'b1;
      @(posedge clock);
      m_step();
      #1;
      chk("rnd_tx", 32'(tx_point), 32'(m_tx));
      chk("rnd_sp", 32'(sample_point), 32'(m_sp));
      chk("rnd_sbit", 32'(sampled_bit), 32'(m_sbit));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
